// File: rtl/hub75_pkg.sv
// Shared constants and types for the HUB75 panel sink.
package hub75_pkg;

    localparam int unsigned COLS_DEF         = 64;
    localparam int unsigned ROW_BITS_DEF     = 4;
    localparam int unsigned ONTIME_WIDTH_DEF = 16;
    localparam int unsigned SYNC_STAGES_DEF  = 2;
    localparam int unsigned RGB_W            = 6;

    // Bit positions inside the {b2,g2,r2,b1,g1,r1} pixel field.
    localparam int unsigned R1 = 0;
    localparam int unsigned G1 = 1;
    localparam int unsigned B1 = 2;
    localparam int unsigned R2 = 3;
    localparam int unsigned G2 = 4;
    localparam int unsigned B2 = 5;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } stream_state_e;

    typedef struct packed {
        logic [ROW_BITS_DEF-1:0]      row;
        logic [$clog2(COLS_DEF)-1:0]  col;
        logic [RGB_W-1:0]             rgb;
        logic [ONTIME_WIDTH_DEF-1:0]  on_time;
        logic                         last;
    } pixel_rec_t;

endpackage

// File: rtl/hub75_input_sync.sv
// Synchronises the panel pins into clk_in and produces registered edge pulses,
// with row/rgb delayed by the same amount so data lines up with each pulse.
module hub75_input_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ROW_BITS    = 4,
    parameter int unsigned RGB_W       = 6
) (
    input  logic                clk_in,
    input  logic                reset,
    input  logic                panel_clk,
    input  logic                panel_latch,
    input  logic                panel_oe,
    input  logic [ROW_BITS-1:0] panel_row,
    input  logic [RGB_W-1:0]    panel_rgb,
    output logic                clk_rise,
    output logic                latch_rise,
    output logic                oe_rise,
    output logic                oe_fall,
    output logic                oe_level,
    output logic [ROW_BITS-1:0] row,
    output logic [RGB_W-1:0]    rgb
);

    localparam int unsigned W = 3 + ROW_BITS + RGB_W;

    logic [SYNC_STAGES-1:0][W-1:0] sync_q;
    logic [W-1:0]                  tap;
    logic [2:0]                    ctl;
    logic [2:0]                    ctl_dly;

    assign tap = sync_q[SYNC_STAGES-1];
    assign ctl = tap[W-1 -: 3];  // {oe, latch, clk}

    always_ff @(posedge clk_in) begin
        if (reset) begin
            sync_q     <= '0;
            ctl_dly    <= '0;
            clk_rise   <= 1'b0;
            latch_rise <= 1'b0;
            oe_rise    <= 1'b0;
            oe_fall    <= 1'b0;
            oe_level   <= 1'b0;
            row        <= '0;
            rgb        <= '0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0],
                           {panel_oe, panel_latch, panel_clk, panel_row, panel_rgb}};
            ctl_dly    <= ctl;
            clk_rise   <= ctl[0] & ~ctl_dly[0];
            latch_rise <= ctl[1] & ~ctl_dly[1];
            oe_rise    <= ctl[2] & ~ctl_dly[2];
            oe_fall    <= ~ctl[2] & ctl_dly[2];
            oe_level   <= ctl[2];
            row        <= tap[RGB_W +: ROW_BITS];
            rgb        <= tap[RGB_W-1:0];
        end
    end

endmodule

// File: rtl/hub75_panel_sink.sv
// HUB75 panel model: shifts and latches a row, times each OE pulse, then streams
// the lit row as one record per pixel over a valid/ready interface.
module hub75_panel_sink
    import hub75_pkg::*;
#(
    parameter int unsigned COLS         = COLS_DEF,
    parameter int unsigned ROW_BITS     = ROW_BITS_DEF,
    parameter int unsigned ONTIME_WIDTH = ONTIME_WIDTH_DEF,
    parameter int unsigned SYNC_STAGES  = SYNC_STAGES_DEF
) (
    input  logic                      clk_in,
    input  logic                      reset,
    input  logic                      panel_clk,
    input  logic                      panel_latch,
    input  logic                      panel_oe,
    input  logic [ROW_BITS-1:0]       panel_row,
    input  logic [5:0]                panel_rgb,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ROW_BITS-1:0]       out_row,
    output logic [$clog2(COLS)-1:0]   out_col,
    output logic [5:0]                out_rgb,
    output logic [ONTIME_WIDTH-1:0]   out_on_time,
    output logic                      out_last,
    input  logic                      clear_status,
    output logic                      err_count,
    output logic                      err_overflow,
    output logic [7:0]                drop_count
);

    localparam int unsigned COL_W = $clog2(COLS);
    localparam int unsigned CNT_W = $clog2(COLS + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(COLS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(COLS + 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

    logic                clk_rise, latch_rise, oe_rise, oe_fall, oe_level;
    logic [ROW_BITS-1:0] row_s;
    logic [RGB_W-1:0]    rgb_s;

    hub75_input_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .ROW_BITS    (ROW_BITS),
        .RGB_W       (RGB_W)
    ) u_sync (
        .clk_in      (clk_in),
        .reset       (reset),
        .panel_clk   (panel_clk),
        .panel_latch (panel_latch),
        .panel_oe    (panel_oe),
        .panel_row   (panel_row),
        .panel_rgb   (panel_rgb),
        .clk_rise    (clk_rise),
        .latch_rise  (latch_rise),
        .oe_rise     (oe_rise),
        .oe_fall     (oe_fall),
        .oe_level    (oe_level),
        .row         (row_s),
        .rgb         (rgb_s)
    );

    logic [COLS-1:0][RGB_W-1:0] shift_reg, shift_next, latch_reg, pix_buf, pix_src;
    logic [CNT_W-1:0]           shift_cnt, cnt_next;
    logic [ROW_BITS-1:0]        row_cap;
    logic [ONTIME_WIDTH-1:0]    on_time;

    stream_state_e              state_q, state_d;
    logic [COL_W-1:0]           col_d;
    logic                       load;
    logic                       overflow;
    logic                       count_bad;

    // Shift applied before latch so a coincident latch captures the new pixel.
    always_comb begin
        shift_next = shift_reg;
        cnt_next   = shift_cnt;
        if (clk_rise) begin
            shift_next = {shift_reg[COLS-2:0], rgb_s};
            if (shift_cnt != CNT_SAT) begin
                cnt_next = shift_cnt + CNT_W'(1);
            end
        end
    end

    assign count_bad = latch_rise && (cnt_next != CNT_FULL);

    always_ff @(posedge clk_in) begin
        if (reset) begin
            shift_reg <= '0;
            latch_reg <= '0;
            shift_cnt <= '0;
        end else begin
            shift_reg <= shift_next;
            if (latch_rise) begin
                latch_reg <= shift_next;
                shift_cnt <= '0;
            end else begin
                shift_cnt <= cnt_next;
            end
        end
    end

    // OE pulse width in clk_in cycles, saturating.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            row_cap <= '0;
            on_time <= '0;
        end else if (oe_rise) begin
            row_cap <= row_s;
            on_time <= ONTIME_WIDTH'(1);
        end else if (oe_level && (on_time != '1)) begin
            on_time <= on_time + ONTIME_WIDTH'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = out_col;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (oe_fall) begin
                    load    = 1'b1;
                    state_d = ST_STREAM;
                    col_d   = '0;
                end
            end
            ST_STREAM: begin
                if (out_ready) begin
                    if (out_col == COL_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        col_d = out_col + COL_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign overflow = oe_fall && !load;
    assign pix_src  = load ? latch_reg : pix_buf;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pix_buf     <= '0;
            out_valid   <= 1'b0;
            out_row     <= '0;
            out_col     <= '0;
            out_rgb     <= '0;
            out_on_time <= '0;
            out_last    <= 1'b0;
        end else begin
            state_q   <= state_d;
            out_valid <= (state_d == ST_STREAM);
            out_col   <= col_d;
            out_rgb   <= pix_src[col_d];
            out_last  <= (state_d == ST_STREAM) && (col_d == COL_LAST);
            if (load) begin
                pix_buf     <= latch_reg;
                out_row     <= row_cap;
                out_on_time <= on_time;
            end
        end
    end

    // Sticky status: a new error in the clearing cycle wins.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            err_count    <= 1'b0;
            err_overflow <= 1'b0;
            drop_count   <= '0;
        end else begin
            err_count    <= (err_count & ~clear_status) | count_bad;
            err_overflow <= (err_overflow & ~clear_status) | overflow;
            if (clear_status) begin
                drop_count <= overflow ? 8'd1 : 8'd0;
            end else if (overflow && (drop_count != 8'hFF)) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

endmodule
